usb_crc_check: RTL and testbench

- Parametrised serial CRC checker for the USB receive path; one instance handles either CRC5 (token) or CRC16 (data) packets.
- Sits between the bit-unstuffer and the packet decoder and accepts LSB-first bits with a valid qualifier, so stalls for stuffed bits are tolerated.
- Forwards payload bits with the trailing CRC field stripped, using a CRC_W-deep delay line.
- At end-of-packet it reports pass/fail by comparing the CRC register against the protocol residual.

---
 rtl/usb_crc_check.sv | 129 ++++++++++++
 tb/tb_usb_crc_check.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_crc_check.sv
// Serial USB CRC checker: accepts LSB-first bits, forwards the payload with the trailing
// CRC field stripped, and reports pass/fail against the protocol residual at end-of-packet.
module usb_crc_check #(
  parameter int unsigned CRC_W    = 16,
  parameter logic [15:0] POLY     = 16'h8005,
  parameter logic [15:0] RESIDUAL = 16'h800D,
  parameter int unsigned MAX_BITS = 8200,
  parameter int unsigned CNT_W    = 14
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_eop,
  output logic             out_valid,
  output logic             out_bit,
  output logic             done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             short_pkt,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned FillW = $clog2(CRC_W + 1);
  localparam logic [FillW-1:0] FillFull = FillW'(CRC_W);
  localparam logic [CNT_W-1:0] CntSat = CNT_W'(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] CntMin = CNT_W'(CRC_W);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CRC_W-1:0]   dly_q, dly_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic               out_bit_q, out_bit_d;

  logic               accept;
  logic               fb;
  logic [CRC_W-1:0]   crc_shift;
  logic               short_raw;
  logic               ok_raw;

  // Bits arriving while the result is being reported are dropped.
  assign accept    = in_valid && (state_q != StCheck);
  assign fb        = in_bit ^ crc_q[CRC_W-1];
  assign crc_shift = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY[CRC_W-1:0] : '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_eop) begin
          state_d = StCheck;
        end else if (in_valid) begin
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (in_eop) begin
          state_d = StCheck;
        end
      end
      StCheck: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    crc_d       = crc_q;
    dly_d       = dly_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_bit_d   = out_bit_q;
    if (state_q == StCheck) begin
      crc_d  = '1;
      fill_d = '0;
      cnt_d  = '0;
    end else if (accept) begin
      crc_d = crc_shift;
      dly_d = {dly_q[CRC_W-2:0], in_bit};
      // The newest CRC_W bits may turn out to be the CRC field, so only older bits leave.
      if (fill_q == FillFull) begin
        out_valid_d = 1'b1;
        out_bit_d   = dly_q[CRC_W-1];
      end else begin
        fill_d = fill_q + 1'b1;
      end
      if (cnt_q != CntSat) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      crc_q       <= '1;
      dly_q       <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      dly_q       <= dly_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
    end
  end

  assign short_raw = cnt_q < CntMin;
  assign ok_raw    = !short_raw && (cnt_q <= CntMax) && (crc_q == RESIDUAL[CRC_W-1:0]);

  assign done      = (state_q == StCheck);
  assign crc_ok    = done && ok_raw;
  assign crc_err   = done && !ok_raw;
  assign short_pkt = done && short_raw;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign bit_count = cnt_q;

endmodule

// File: tb/tb_usb_crc_check.sv
// Randomised scoreboard bench for usb_crc_check, covering a CRC5 and a CRC16 instance.
module tb_usb_crc_check;

  localparam int unsigned Max5  = 40;
  localparam int unsigned Max16 = 8200;

  typedef bit bq_t[$];
  typedef struct {
    bit ok;
    bit err;
    bit sh;
    int cnt;
    int cyc;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic v5 = 1'b0, b5 = 1'b0, e5 = 1'b0;
  logic ov5, ob5, d5, ok5, er5, sh5;
  logic [5:0] bc5;
  logic v16 = 1'b0, b16 = 1'b0, e16 = 1'b0;
  logic ov16, ob16, d16, ok16, er16, sh16;
  logic [13:0] bc16;

  usb_crc_check #(
    .CRC_W(5), .POLY(16'h0005), .RESIDUAL(16'h000C), .MAX_BITS(Max5), .CNT_W(6)
  ) u_dut5 (
    .clock(clock), .reset(reset), .in_valid(v5), .in_bit(b5), .in_eop(e5),
    .out_valid(ov5), .out_bit(ob5), .done(d5), .crc_ok(ok5), .crc_err(er5),
    .short_pkt(sh5), .bit_count(bc5)
  );

  usb_crc_check #(
    .CRC_W(16), .POLY(16'h8005), .RESIDUAL(16'h800D), .MAX_BITS(Max16), .CNT_W(14)
  ) u_dut16 (
    .clock(clock), .reset(reset), .in_valid(v16), .in_bit(b16), .in_eop(e16),
    .out_valid(ov16), .out_bit(ob16), .done(d16), .crc_ok(ok16), .crc_err(er16),
    .short_pkt(sh16), .bit_count(bc16)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit   exp_bits5[$], exp_bits16[$];
  res_t exp_res5[$], exp_res16[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transmitted CRC field from mod-2 long division of the payload, with the first CRC_W
  // coefficients inverted (all-ones preset) and the remainder sent complemented, MSB first.
  function automatic bq_t crc_field(input int w, input logic [15:0] poly, input bq_t p);
    bq_t a;
    bq_t f;
    int n;
    n = p.size();
    a = p;
    for (int i = 0; i < w; i++) a.push_back(1'b0);
    for (int i = 0; i < w; i++) a[i] = ~a[i];
    for (int k = 0; k < n; k++) begin
      if (a[k]) begin
        a[k] = 1'b0;
        for (int j = 0; j < w; j++) a[k + w - j] = a[k + w - j] ^ poly[j];
      end
    end
    for (int t = 0; t < w; t++) f.push_back(~a[n + t]);
    return f;
  endfunction

  task automatic expect_pkt(input int sel, input bq_t b, output res_t r);
    int w, mx, len;
    logic [15:0] poly;
    bq_t pay, fld, ref_f;
    w    = (sel == 5) ? 5 : 16;
    mx   = (sel == 5) ? Max5 : Max16;
    poly = (sel == 5) ? 16'h0005 : 16'h8005;
    len  = b.size();
    r.sh = (len < w);
    r.ok = 1'b0;
    if (!r.sh) begin
      for (int i = 0; i < len - w; i++) pay.push_back(b[i]);
      for (int i = len - w; i < len; i++) fld.push_back(b[i]);
      ref_f = crc_field(w, poly, pay);
      r.ok = (len <= mx);
      for (int t = 0; t < w; t++) if (fld[t] != ref_f[t]) r.ok = 1'b0;
      foreach (pay[i]) begin
        if (sel == 5) exp_bits5.push_back(pay[i]);
        else exp_bits16.push_back(pay[i]);
      end
    end
    r.err = !r.ok;
    r.cnt = (len > mx) ? mx + 1 : len;
    r.cyc = 0;
  endtask

  task automatic set_in(input int sel, input logic v, input logic b, input logic e);
    if (sel == 5) begin
      v5 = v; b5 = b; e5 = e;
    end else begin
      v16 = v; b16 = b; e16 = e;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int sel, input bq_t b, input bit eop_last, input int gap_at,
                      input int gap_len);
    res_t r;
    int n;
    n = b.size();
    expect_pkt(sel, b, r);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          set_in(sel, 1'b0, 1'b0, 1'b0);
          step();
        end
      end
      set_in(sel, 1'b1, b[i], eop_last && (i == n - 1));
      if (eop_last && (i == n - 1)) r.cyc = cyc + 1;
      step();
    end
    if (!(eop_last && n > 0)) begin
      set_in(sel, 1'b0, 1'b0, 1'b1);
      r.cyc = cyc + 1;
      step();
    end
    set_in(sel, 1'b0, 1'b0, 1'b0);
    if (sel == 5) exp_res5.push_back(r);
    else exp_res16.push_back(r);
    step();
    step();
  endtask

  always @(negedge clock) begin
    res_t r;
    if (ov5) begin
      if (exp_bits5.size() == 0) chk("out5_unexpected", 1, 0);
      else chk("out5_bit", ob5, exp_bits5.pop_front());
    end
    if (d5) begin
      if (exp_res5.size() == 0) chk("done5_unexpected", 1, 0);
      else begin
        r = exp_res5.pop_front();
        chk("done5_cycle", cyc, r.cyc);
        chk("crc_ok5", ok5, r.ok);
        chk("crc_err5", er5, r.err);
        chk("short5", sh5, r.sh);
        chk("bit_count5", bc5, r.cnt);
      end
    end else if (ok5 || er5 || sh5) chk("flags5_outside_done", 1, 0);
    if (ov16) begin
      if (exp_bits16.size() == 0) chk("out16_unexpected", 1, 0);
      else chk("out16_bit", ob16, exp_bits16.pop_front());
    end
    if (d16) begin
      if (exp_res16.size() == 0) chk("done16_unexpected", 1, 0);
      else begin
        r = exp_res16.pop_front();
        chk("done16_cycle", cyc, r.cyc);
        chk("crc_ok16", ok16, r.ok);
        chk("crc_err16", er16, r.err);
        chk("short16", sh16, r.sh);
        chk("bit_count16", bc16, r.cnt);
      end
    end else if (ok16 || er16 || sh16) chk("flags16_outside_done", 1, 0);
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_ov5"}, ov5, 0);
    chk({tag, "_done5"}, d5, 0);
    chk({tag, "_flags5"}, {ok5, er5, sh5}, 0);
    chk({tag, "_bc5"}, bc5, 0);
    chk({tag, "_ov16"}, ov16, 0);
    chk({tag, "_done16"}, d16, 0);
    chk({tag, "_flags16"}, {ok16, er16, sh16}, 0);
    chk({tag, "_bc16"}, bc16, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b, p, f;
    int n, mode, sel, w;
    step();
    step();
    chk_idle("reset");
    reset = 1'b0;
    step();

    // SETUP addr 0 endp 0, then corrupted, then with a mid-packet stall
    b = {};
    for (int i = 0; i < 11; i++) b.push_back(1'b0);
    b.push_back(1'b0); b.push_back(1'b1); b.push_back(1'b0); b.push_back(1'b0);
    b.push_back(1'b0);
    send(5, b, 1'b0, -1, 0);
    b[12] = 1'b0;
    send(5, b, 1'b0, -1, 0);
    b[12] = 1'b1;
    send(5, b, 1'b1, 6, 3);

    // Zero-length DATA0, short packet, empty packet
    b = {};
    for (int i = 0; i < 16; i++) b.push_back(1'b0);
    send(16, b, 1'b0, -1, 0);
    b = {};
    b.push_back(1'b1); b.push_back(1'b0); b.push_back(1'b1);
    send(16, b, 1'b1, -1, 0);
    b = {};
    send(16, b, 1'b0, -1, 0);
    send(5, b, 1'b1, -1, 0);

    // MAX_BITS boundary on the CRC5 instance: exactly full, then one over
    for (int k = 35; k <= 36; k++) begin
      p = {};
      for (int i = 0; i < k; i++) p.push_back(1'($urandom));
      f = crc_field(5, 16'h0005, p);
      b = p;
      foreach (f[i]) b.push_back(f[i]);
      send(5, b, 1'($urandom), -1, 0);
    end

    // Abort a CRC16 packet with reset after 8 bits
    for (int i = 0; i < 8; i++) begin
      set_in(16, 1'b1, 1'($urandom), 1'b0);
      step();
    end
    set_in(16, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    step();
    chk_idle("abort");
    reset = 1'b0;
    step();
    b = {};
    for (int i = 0; i < 16; i++) b.push_back(1'b0);
    send(16, b, 1'b1, -1, 0);

    // Randomised packets on both instances
    for (int it = 0; it < 50; it++) begin
      sel  = (it % 2 == 0) ? 5 : 16;
      w    = (sel == 5) ? 5 : 16;
      n    = (sel == 5) ? $urandom_range(0, 40) : $urandom_range(0, 48);
      mode = $urandom_range(0, 3);
      p = {};
      for (int i = 0; i < n; i++) p.push_back(1'($urandom));
      f = crc_field(w, (sel == 5) ? 16'h0005 : 16'h8005, p);
      b = p;
      foreach (f[i]) b.push_back(f[i]);
      if (mode == 1) begin
        int fi;
        fi = n + $urandom_range(0, w - 1);
        b[fi] = ~b[fi];
      end else if (mode == 2) begin
        b = {};
        for (int i = 0; i < $urandom_range(0, w - 1); i++) b.push_back(1'($urandom));
      end
      send(sel, b, 1'($urandom), $urandom_range(0, b.size()), $urandom_range(0, 3));
    end

    for (int i = 0; i < 4; i++) step();
    chk("drain5", exp_bits5.size() + exp_res5.size(), 0);
    chk("drain16", exp_bits16.size() + exp_res16.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
